// File: rtl/tof_pkg.sv
// Shared types and register-map constants for the time-of-flight counter.
package tof_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd1;
  localparam logic [1:0] ADDR_BLANK   = 2'd2;
  localparam logic [1:0] ADDR_RESULT  = 2'd3;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_CLEAR   = 2;
  localparam int STAT_BUSY    = 4;
  localparam int STAT_VALID   = 5;
  localparam int STAT_TIMEOUT = 6;
  localparam int STAT_OVERRUN = 7;

endpackage

// File: rtl/tof_counter_avmm_if.sv
// Avalon-MM slave bus bundle for the time-of-flight counter register file.
interface tof_counter_avmm_if;
  logic        avms_cs;
  logic [1:0]  avms_addr;
  logic        avms_write;
  logic [31:0] avms_writedata;
  logic        avms_read;
  logic [31:0] avms_readdata;

  modport master (
    output avms_cs, avms_addr, avms_write, avms_writedata, avms_read,
    input  avms_readdata
  );

  modport slave (
    input  avms_cs, avms_addr, avms_write, avms_writedata, avms_read,
    output avms_readdata
  );
endinterface

// File: rtl/edge_sync.sv
// Purpose: synchronise an asynchronous input and emit a one-cycle rising-edge pulse.
// Latency: STAGES cycles from input rise to pulse.
// Backpressure: none, free-running.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign pulse = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tof_counter_avmm.sv
// Purpose: time laser_en rise to first unblanked echo rise, report over Avalon-MM.
// Latency: read data one cycle after read strobe; valid one cycle after echo edge.
// Backpressure: none, slave accepts every access with fixed timing.
module tof_counter_avmm
  import tof_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                avms_clk,
  input  logic                avms_reset_n,
  tof_counter_avmm_if.slave   avms,
  input  logic                laser_en,
  input  logic                echo,
  output logic                tof_irq
);

  logic             laser_p, echo_p;
  logic             enable, irq_en, valid, to_flag, overrun;
  logic [CNT_W-1:0] timeout_val, result, cnt;
  logic [15:0]      blank;
  state_t           state, state_d;
  logic             busy, store, store_to, restart, start;
  logic             echo_hit, to_hit;
  logic             wr_en, rd_en, ctrl_wr, clear, result_rd;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  edge_sync #(.STAGES(SYNC_STAGES)) u_laser_sync (
    .clk(avms_clk), .rst_n(avms_reset_n), .din(laser_en), .pulse(laser_p)
  );
  edge_sync #(.STAGES(SYNC_STAGES)) u_echo_sync (
    .clk(avms_clk), .rst_n(avms_reset_n), .din(echo), .pulse(echo_p)
  );

  assign wr_en     = avms.avms_cs & avms.avms_write;
  assign rd_en     = avms.avms_cs & avms.avms_read;
  assign ctrl_wr   = wr_en && (avms.avms_addr == ADDR_CTRL);
  assign clear     = ctrl_wr & avms.avms_writedata[CTRL_CLEAR];
  assign result_rd = rd_en && (avms.avms_addr == ADDR_RESULT);
  assign unused_wd = ^avms.avms_writedata;

  // The counter reads 1 on the first COUNT cycle, so a stored value equals the
  // number of cycles between the start and stop edges.
  assign echo_hit = echo_p && (32'(cnt) >= 32'(blank));
  assign to_hit   = cnt >= timeout_val;

  always_ff @(posedge avms_clk or negedge avms_reset_n) begin
    if (!avms_reset_n) state <= IDLE;
    else               state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    state_d = ARMED;
        ARMED:   if (laser_p) state_d = COUNT;
        COUNT:   if (store) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state == COUNT);
    start    = enable && (state == ARMED) && laser_p;
    restart  = enable && busy && laser_p;
    store    = enable && busy && !laser_p && (echo_hit || to_hit);
    store_to = !echo_hit;
  end

  always_ff @(posedge avms_clk or negedge avms_reset_n) begin
    if (!avms_reset_n) begin
      cnt <= '0;
    end else if (start || restart) begin
      cnt <= CNT_W'(1);
    end else if (busy && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A store always beats a simultaneous clear or RESULT read.
  always_ff @(posedge avms_clk or negedge avms_reset_n) begin
    if (!avms_reset_n) begin
      result  <= '0;
      valid   <= 1'b0;
      to_flag <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (store) begin
        result  <= store_to ? '1 : cnt;
        valid   <= 1'b1;
        to_flag <= store_to;
      end else begin
        if (clear || result_rd) valid <= 1'b0;
        if (clear)              to_flag <= 1'b0;
      end
      if ((store && valid) || restart) overrun <= 1'b1;
      else if (clear)                  overrun <= 1'b0;
    end
  end

  always_ff @(posedge avms_clk or negedge avms_reset_n) begin
    if (!avms_reset_n) begin
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      timeout_val <= '1;
      blank       <= '0;
    end else if (wr_en) begin
      case (avms.avms_addr)
        ADDR_CTRL: begin
          enable <= avms.avms_writedata[CTRL_ENABLE];
          irq_en <= avms.avms_writedata[CTRL_IRQ_EN];
        end
        ADDR_TIMEOUT: timeout_val <= avms.avms_writedata[CNT_W-1:0];
        ADDR_BLANK:   blank       <= avms.avms_writedata[15:0];
        default:      ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avms.avms_addr)
      ADDR_CTRL: begin
        rd_mux[CTRL_ENABLE]  = enable;
        rd_mux[CTRL_IRQ_EN]  = irq_en;
        rd_mux[STAT_BUSY]    = busy;
        rd_mux[STAT_VALID]   = valid;
        rd_mux[STAT_TIMEOUT] = to_flag;
        rd_mux[STAT_OVERRUN] = overrun;
      end
      ADDR_TIMEOUT: rd_mux = 32'(timeout_val);
      ADDR_BLANK:   rd_mux = 32'(blank);
      default:      rd_mux = 32'(result);
    endcase
  end

  always_ff @(posedge avms_clk or negedge avms_reset_n) begin
    if (!avms_reset_n)  avms.avms_readdata <= '0;
    else if (rd_en)     avms.avms_readdata <= rd_mux;
  end

  assign tof_irq = valid & irq_en;

endmodule

// File: tb/tb_tof_counter_avmm.sv
// Randomised and directed shots against a per-shot arithmetic model of the ToF counter.
module tb_tof_counter_avmm;

  localparam int          MAXC = 40000;
  localparam logic [31:0] ALL1 = 32'h00FF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic laser_en = 1'b0;
  logic echo = 1'b0;
  logic tof_irq;

  tof_counter_avmm_if bus ();

  tof_counter_avmm #(.CNT_W(24), .SYNC_STAGES(2)) dut (
    .avms_clk     (clk),
    .avms_reset_n (rst_n),
    .avms         (bus),
    .laser_en     (laser_en),
    .echo         (echo),
    .tof_irq      (tof_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit laser_sched [MAXC];
  bit echo_sched  [MAXC];
  int echo_q [$];

  bit          m_en, m_irq_en, m_valid, m_to, m_ovr;
  logic [31:0] m_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Both async inputs are driven from a per-cycle schedule on the same phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < MAXC) begin
        laser_en = laser_sched[cyc];
        echo     = echo_sched[cyc];
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic sched_laser(input int at);
    if (at + 1 < MAXC) begin
      laser_sched[at]   = 1'b1;
      laser_sched[at+1] = 1'b1;
    end
  endtask

  task automatic sched_echo(input int at);
    if (at + 1 < MAXC) begin
      echo_sched[at]   = 1'b1;
      echo_sched[at+1] = 1'b1;
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    bus.avms_cs = 1'b1; bus.avms_write = 1'b1; bus.avms_addr = a; bus.avms_writedata = d;
    @(posedge clk); #2;
    bus.avms_cs = 1'b0; bus.avms_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #2;
    bus.avms_cs = 1'b1; bus.avms_read = 1'b1; bus.avms_addr = a;
    @(posedge clk); #2;
    bus.avms_cs = 1'b0; bus.avms_read = 1'b0;
    d = bus.avms_readdata;
  endtask

  task automatic wr_ctrl(input bit en, input bit ie, input bit clr);
    bus_wr(2'd0, {29'd0, clr, ie, en});
    m_en = en;
    m_irq_en = ie;
    if (clr) begin
      m_valid = 1'b0; m_to = 1'b0; m_ovr = 1'b0;
    end
  endtask

  task automatic check_status(input string tag, input bit busy);
    logic [31:0] d;
    bus_rd(2'd0, d);
    check(tag, d, {24'd0, m_ovr, m_to, m_valid, busy, 2'b00, m_irq_en, m_en});
    @(negedge clk);
    check({tag, "_irq"}, {31'd0, tof_irq}, {31'd0, m_valid & m_irq_en});
  endtask

  task automatic read_result(input string tag);
    logic [31:0] d;
    bus_rd(2'd3, d);
    check(tag, d, m_res);
    m_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_en = 0; m_irq_en = 0; m_valid = 0; m_to = 0; m_ovr = 0; m_res = 32'd0;
  endtask

  // One shot: start edge (optionally a restart r cycles later), echoes at echo_q
  // offsets from the last start. First echo in [blank, timeout] wins, else timeout.
  task automatic run_shot(input int b, input int t, input int r);
    int          s, base, end_c;
    bit          found;
    logic [31:0] exp;
    bus_wr(2'd2, b);
    bus_wr(2'd1, t);
    s = cyc + 3;
    sched_laser(s);
    base = s;
    if (r > 0) begin
      sched_laser(s + r);
      base = s + r;
    end
    foreach (echo_q[i]) sched_echo(base + echo_q[i]);
    end_c = base + t + 10;
    while (cyc < end_c) @(posedge clk);
    found = 1'b0;
    exp   = ALL1;
    foreach (echo_q[i]) begin
      if (!found && echo_q[i] >= b && echo_q[i] <= t) begin
        found = 1'b1;
        exp   = echo_q[i];
      end
    end
    m_ovr   = m_ovr | m_valid | (r > 0);
    m_valid = 1'b1;
    m_res   = exp;
    m_to    = !found;
    echo_q.delete();
  endtask

  initial begin
    logic [31:0] d;
    int          s, b, t, r, n, dd;
    bit          ie;

    bus.avms_cs = 0; bus.avms_write = 0; bus.avms_read = 0;
    bus.avms_addr = 0; bus.avms_writedata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    bus_rd(2'd0, d); check("rst_ctrl", d, 32'd0);
    bus_rd(2'd1, d); check("rst_timeout", d, ALL1);
    bus_rd(2'd2, d); check("rst_blank", d, 32'd0);
    bus_rd(2'd3, d); check("rst_result", d, 32'd0);
    @(negedge clk);
    check("rst_irq", {31'd0, tof_irq}, 32'd0);

    wr_ctrl(1'b1, 1'b1, 1'b0);

    echo_q = '{100};
    run_shot(0, 200, 0);
    check_status("k100_stat", 1'b0);
    read_result("k100_res");
    check_status("k100_after_rd", 1'b0);

    echo_q = '{5, 50};
    run_shot(20, 200, 0);
    check_status("blank_stat", 1'b0);
    read_result("blank_res");

    run_shot(0, 30, 0);
    check_status("tmo_stat", 1'b0);
    read_result("tmo_res");

    echo_q = '{30};
    run_shot(0, 30, 0);
    check_status("tmo_tie_stat", 1'b0);
    read_result("tmo_tie_res");

    echo_q = '{40};
    run_shot(0, 200, 10);
    check_status("ovr_stat", 1'b0);
    read_result("ovr_res");
    wr_ctrl(1'b1, 1'b1, 1'b1);
    check_status("ovr_clear", 1'b0);

    // Disable mid-count: the pending shot is dropped.
    bus_wr(2'd1, 32'd200);
    s = cyc + 3;
    sched_laser(s);
    sched_echo(s + 60);
    while (cyc < s + 20) @(posedge clk);
    check_status("dis_busy", 1'b1);
    wr_ctrl(1'b0, 1'b1, 1'b0);
    while (cyc < s + 75) @(posedge clk);
    check_status("dis_idle", 1'b0);
    read_result("dis_res");
    wr_ctrl(1'b1, 1'b1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      b  = $urandom_range(0, 40);
      t  = $urandom_range(20, 120);
      r  = ($urandom_range(0, 3) == 0) ? $urandom_range(5, t - 1) : 0;
      n  = $urandom_range(0, 3);
      ie = 1'($urandom_range(0, 1));
      dd = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) begin
        if (dd <= t + 5) echo_q.push_back(dd);
        dd += $urandom_range(3, 40);
      end
      wr_ctrl(1'b1, ie, 1'b0);
      run_shot(b, t, r);
      check_status("rnd_stat", 1'b0);
      if ($urandom_range(0, 3) != 0) read_result("rnd_res");
      if ($urandom_range(0, 4) == 0) wr_ctrl(1'b1, ie, 1'b1);
    end

    // Leave a result pending, then reset asynchronously in the middle of a count.
    wr_ctrl(1'b1, 1'b1, 1'b0);
    echo_q = '{25};
    run_shot(0, 200, 0);
    check_status("prerst_stat", 1'b0);
    s = cyc + 3;
    sched_laser(s);
    sched_echo(s + 80);
    while (cyc < s + 20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("rst_async_irq", {31'd0, tof_irq}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bus_rd(2'd0, d); check("rst2_ctrl", d, 32'd0);
    bus_rd(2'd1, d); check("rst2_timeout", d, ALL1);
    bus_rd(2'd2, d); check("rst2_blank", d, 32'd0);
    bus_rd(2'd3, d); check("rst2_result", d, 32'd0);
    while (cyc < s + 95) @(posedge clk);
    check_status("rst2_after_echo", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
